// File: rtl/la_pkg.sv
// Shared constants for the logic-analyzer capture path: state encoding,
// buffer geometry and trigger-mode values.
package la_pkg;

  localparam int LA_DEPTH = 49152;
  localparam int LA_CNT_W = 16;
  localparam int LA_DIV_W = 16;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CLEAR    = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] ARMED    = 3'd3;
  localparam logic [2:0] CAPTURE  = 3'd4;
  localparam logic [2:0] RD_ISSUE = 3'd5;
  localparam logic [2:0] RD_WAIT  = 3'd6;
  localparam logic [2:0] RD_SEND  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = IDLE,
    ST_CLEAR    = CLEAR,
    ST_SETTLE   = SETTLE,
    ST_ARMED    = ARMED,
    ST_CAPTURE  = CAPTURE,
    ST_RD_ISSUE = RD_ISSUE,
    ST_RD_WAIT  = RD_WAIT,
    ST_RD_SEND  = RD_SEND
  } state_e;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

endpackage

// File: rtl/la_trigger_unit.sv
// Sample-rate prescaler and probe trigger comparator. restart_i reloads the
// prescaler and forces prev_match high so a pre-existing level is not an edge.
module la_trigger_unit
  import la_pkg::*;
#(
  parameter int DIV_W = LA_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [7:0]       mask_i,
  input  logic [7:0]       value_i,
  input  logic             edge_i,
  input  logic [7:0]       probe_i,
  output logic             strobe_o,
  output logic             fire_o
);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic             prev_q, prev_d;
  logic             match;

  assign match    = ((probe_i ^ value_i) & mask_i) == 8'h00;
  assign strobe_o = run_i && (presc_q == div_i);
  assign fire_o   = strobe_o && ((edge_i == TRIG_EDGE) ? (match && !prev_q) : match);

  always_comb begin
    presc_d = presc_q;
    prev_d  = prev_q;
    if (restart_i) begin
      presc_d = '0;
      prev_d  = 1'b1;
    end else if (run_i) begin
      if (strobe_o) begin
        presc_d = '0;
        prev_d  = match;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      prev_q  <= 1'b1;
    end else begin
      presc_q <= presc_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: clears the sample buffer, waits for a trigger, writes
// eff_len samples, then streams the buffer out on a byte valid/ready link.
module capture_ctrl
  import la_pkg::*;
#(
  parameter int DEPTH = LA_DEPTH,
  parameter int CNT_W = LA_CNT_W,
  parameter int DIV_W = LA_DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [7:0]       cfg_trig_mask,
  input  logic [7:0]       cfg_trig_value,
  input  logic             cfg_trig_edge,
  input  logic [7:0]       probe_in,
  output logic             buf_clear,
  output logic             buf_write_en,
  output logic [7:0]       buf_data_in,
  output logic             buf_read_en,
  input  logic [7:0]       buf_data_out,
  input  logic             buf_full,
  input  logic             buf_empty,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             triggered,
  output logic             done,
  output logic [CNT_W-1:0] captured_count,
  output logic [2:0]       dbg_state
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       value_q, value_d;
  logic             edge_q, edge_d;
  logic             wr_q, wr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_left_q, rd_left_d;
  logic [7:0]       txd_q, txd_d;
  logic             trig_q, trig_d;
  logic             strobe, fire;
  logic             rd_finished;

  la_trigger_unit #(.DIV_W(DIV_W)) u_trig (
    .clk       (clk),
    .reset     (reset),
    .restart_i (state_q == ST_SETTLE),
    .run_i     ((state_q == ST_ARMED) || (state_q == ST_CAPTURE)),
    .div_i     (div_q),
    .mask_i    (mask_q),
    .value_i   (value_q),
    .edge_i    (edge_q),
    .probe_i   (probe_in),
    .strobe_o  (strobe),
    .fire_o    (fire)
  );

  assign rd_finished = (rd_left_q == '0) || buf_empty;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    len_d     = len_q;
    mask_d    = mask_q;
    value_d   = value_q;
    edge_d    = edge_q;
    wr_d      = 1'b0;
    wdata_d   = wdata_q;
    count_d   = count_q;
    rd_left_d = rd_left_q;
    txd_d     = txd_q;
    trig_d    = trig_q;
    // Abort outranks arm and every other transition, including in IDLE.
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            div_d   = cfg_div;
            len_d   = ((cfg_len == '0) || (cfg_len > DEPTH_C)) ? DEPTH_C : cfg_len;
            mask_d  = cfg_trig_mask;
            value_d = cfg_trig_value;
            edge_d  = cfg_trig_edge;
            trig_d  = 1'b0;
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: state_d = ST_SETTLE;
        ST_SETTLE: begin
          count_d = '0;
          trig_d  = 1'b0;
          state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (fire) begin
            trig_d  = 1'b1;
            wr_d    = 1'b1;
            wdata_d = probe_in;
            count_d = count_q + 1'b1;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          // Reaching len means the final write is on the bus this cycle.
          if (buf_full || (count_q == len_q)) begin
            rd_left_d = count_q;
            state_d   = ST_RD_ISSUE;
          end else if (strobe) begin
            wr_d    = 1'b1;
            wdata_d = probe_in;
            count_d = count_q + 1'b1;
          end
        end
        ST_RD_ISSUE: state_d = rd_finished ? ST_IDLE : ST_RD_WAIT;
        ST_RD_WAIT: begin
          txd_d   = buf_data_out;
          state_d = ST_RD_SEND;
        end
        ST_RD_SEND: begin
          if (tx_ready) begin
            rd_left_d = rd_left_q - 1'b1;
            state_d   = ST_RD_ISSUE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      len_q     <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      edge_q    <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      count_q   <= '0;
      rd_left_q <= '0;
      txd_q     <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      len_q     <= len_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      edge_q    <= edge_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      rd_left_q <= rd_left_d;
      txd_q     <= txd_d;
      trig_q    <= trig_d;
    end
  end

  // tx handshake: a byte moves when tx_valid && tx_ready on a rising edge;
  // while valid is high without ready, tx_data is held. Only abort drops valid early.
  assign buf_clear      = (state_q == ST_CLEAR) && !abort;
  assign buf_write_en   = wr_q && !abort;
  assign buf_data_in    = wdata_q;
  assign buf_read_en    = (state_q == ST_RD_ISSUE) && !rd_finished && !abort;
  assign tx_valid       = (state_q == ST_RD_SEND) && !abort;
  assign tx_data        = txd_q;
  assign busy           = state_q != ST_IDLE;
  assign triggered      = trig_q;
  assign done           = (state_q == ST_RD_ISSUE) && rd_finished && !abort;
  assign captured_count = count_q;
  assign dbg_state      = state_q;

endmodule
